// File: rtl/inv_syn_pkg.sv
// Shared definitions for the invariant-syndrome blocks: digit width,
// requester id type and the per-digit weight mapping.
package inv_syn_pkg;

  localparam int DIGIT_W           = 2;
  localparam int ZERO_DIGIT_WEIGHT = 4;
  localparam int WEIGHT_W          = 3;

  typedef logic req_id_t;

  localparam req_id_t REQ_ID_0 = 1'b0;
  localparam req_id_t REQ_ID_1 = 1'b1;

  // A zero digit carries the heaviest weight so an all-zero word is not a null syndrome.
  function automatic logic [WEIGHT_W-1:0] weight(input logic [DIGIT_W-1:0] digit);
    if (digit == '0) begin
      weight = WEIGHT_W'(ZERO_DIGIT_WEIGHT);
    end else begin
      weight = {1'b0, digit};
    end
  endfunction

endpackage

// File: rtl/inv_syn_core.sv
// Combinational N-digit weighted sum: sum of weight(digit i) * (i+1).
// Holds no state so other syndrome blocks can reuse it directly.
module inv_syn_core
  import inv_syn_pkg::*;
#(
  parameter int N     = 6,
  parameter int SUM_W = 14
) (
  input  logic [DIGIT_W*N-1:0] word,
  output logic [SUM_W-1:0]     sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum = sum + SUM_W'(weight(word[DIGIT_W*i +: DIGIT_W])) * SUM_W'(i + 1);
    end
  end

endmodule

// File: rtl/inv_syn_arb.sv
// Round-robin share of one weighted-sum datapath between two word requesters,
// with a one-deep response register, full backpressure and served counters.
module inv_syn_arb
  import inv_syn_pkg::*;
#(
  parameter int N     = 6,
  parameter int SUM_W = 14,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [2*N-1:0]       req0_word,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [2*N-1:0]       req1_word,
  output logic                 req1_ready,
  output logic                 rsp_valid,
  output logic                 rsp_id,
  output logic [SUM_W-1:0]     rsp_sum,
  input  logic                 rsp_ready,
  output logic [CNT_W-1:0]     cnt0,
  output logic [CNT_W-1:0]     cnt1
);

  req_id_t          last_grant;
  req_id_t          gnt_id;
  logic             gnt_valid;
  logic             can_accept;
  logic             xfer;
  logic [2*N-1:0]   word_sel;
  logic [SUM_W-1:0] core_sum;

  // Contention goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    gnt_valid = req0_valid || req1_valid;
    gnt_id    = REQ_ID_0;
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_grant;
    end else if (req1_valid) begin
      gnt_id = REQ_ID_1;
    end
  end

  assign can_accept = !rsp_valid || rsp_ready;
  assign req0_ready = can_accept && gnt_valid && (gnt_id == REQ_ID_0);
  assign req1_ready = can_accept && gnt_valid && (gnt_id == REQ_ID_1);
  assign xfer       = can_accept && gnt_valid;
  assign word_sel   = (gnt_id == REQ_ID_1) ? req1_word : req0_word;

  inv_syn_core #(
    .N     (N),
    .SUM_W (SUM_W)
  ) u_core (
    .word (word_sel),
    .sum  (core_sum)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= REQ_ID_0;
      rsp_sum    <= '0;
      last_grant <= REQ_ID_1;
    end else if (xfer) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= gnt_id;
      rsp_sum    <= core_sum;
      last_grant <= gnt_id;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

  // Served counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (xfer && (gnt_id == REQ_ID_0) && (cnt0 != '1)) begin
        cnt0 <= cnt0 + CNT_W'(1);
      end
      if (xfer && (gnt_id == REQ_ID_1) && (cnt1 != '1)) begin
        cnt1 <= cnt1 + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/inv_syn_arb.md
Name: inv_syn_arb

Overview:
Shares one weighted-sum (invariant syndrome) datapath between two DNA-word requesters using round-robin arbitration. Each requester uses a valid/ready handshake. Each result returns on a single response port, tagged with the requester id. Sits between the two word-producing front ends and the downstream syndrome checker, with full backpressure and per-requester served counters.

Parameters:
N, 6, digits per word (2 bits each, word width 2*N)
SUM_W, 14, response sum width
CNT_W, 16, width of per-requester served counters

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
req0_valid  in  1  requester 0 has a word
req0_word  in  2*N  requester 0 word
req0_ready  out  1  requester 0 word accepted this cycle when high with valid
req1_valid  in  1  requester 1 has a word
req1_word  in  2*N  requester 1 word
req1_ready  out  1  requester 1 word accepted this cycle when high with valid
rsp_valid  out  1  response held
rsp_id  out  1  requester that owns the response
rsp_sum  out  SUM_W  weighted sum
rsp_ready  in  1  downstream takes response
cnt0  out  CNT_W  words accepted from requester 0, saturating
cnt1  out  CNT_W  words accepted from requester 1, saturating

Behaviour:
- Reset (rst=0 at a clk edge):
  - rsp_valid=0, rsp_id=0, rsp_sum=0, cnt0=cnt1=0.
  - last_grant=1, so requester 0 wins the first contention.
  - Any in-flight word is discarded.
  - Reset dominates all other inputs.
- Arithmetic:
  - sum = Σ_{i=0..N-1} w(d_i)*(i+1), where d_i = word[2i+1:2i].
  - w(00)=4; otherwise w = numeric value (1,2,3).
  - Compute at SUM_W bits, no truncation for legal N (N=6 max 84).
- can_accept = !rsp_valid || rsp_ready.
- Grant (combinational):
  - Only one requester valid: that requester.
  - Both valid: the one that is not last_grant.
  - None valid: no grant.
- reqX_ready = can_accept && grant==X. Ready may depend on valids; the other requester's ready is 0.
- Transfer on reqX_valid && reqX_ready at edge T:
  - At T+1, rsp_valid=1, rsp_id=X, rsp_sum = sum(word at T).
  - Latency is exactly 1 cycle.
  - last_grant<=X.
  - cntX increments, holding at 2^CNT_W-1.
- Response register holds rsp_id/rsp_sum stable while rsp_valid && !rsp_ready.
- Simultaneous drain and accept (rsp_valid && rsp_ready && new transfer): register reloads with the new result, rsp_valid stays 1. Throughput is 1 word/cycle.
- Drain with no transfer: rsp_valid<=0. rsp_id/rsp_sum keep their last values (don't-care).
- last_grant updates only on an actual transfer. A requester dropping valid does not move the pointer.
- Fairness: with both requesters continuously valid and rsp_ready=1, grants strictly alternate. No requester waits more than one transfer.
- Counters never wrap.

Decomposition:
- Shared package inv_syn_pkg:
  - DIGIT_W=2
  - ZERO_DIGIT_WEIGHT=4
  - typedef of the requester id (1 bit)
  - function weight(digit)
- Sub-module inv_syn_core: purely combinational N-digit weighted sum (params N, SUM_W).
  - The arbiter owns all registers.
  - The core is reusable by other syndrome blocks.

Test Plan:
- Reset then req0 only, word 12'h000, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_sum=84; cnt0=1.
- req1 only, word 12'h555 -> rsp_id=1, rsp_sum=21. Then word 12'h001 -> rsp_sum=81.
- Both valid continuously, req0=12'hFFF, req1=12'hAAA, rsp_ready=1 -> responses alternate id 0,1,0,1 with sums 63,42,63,42; one response per cycle.
- Backpressure:
  - rsp_ready=0 for 3 cycles with a response held -> both readys 0, rsp_sum/rsp_id stable.
  - rsp_ready=1 -> same-cycle accept of the next word, rsp_valid never drops.
- Reset asserted (rst=0) mid-stream with rsp_valid=1 -> next cycle rsp_valid=0, cnt0=cnt1=0.
  - Both valid after release -> requester 0 granted first.
- Force cnt0 near max (CNT_W=4 build, 16 transfers) -> cnt0 stays 15.
